// File: rtl/arb2x1.sv
// Two-requester round-robin arbiter driving a 2:1 data mux with a registered,
// valid-qualified output. A bounded hold counter keeps either side from starving.
module arb2x1 #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          last;
  logic          xfer;
  logic          enter;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        case (req)
          2'b01:   state_nxt = OWN0;
          2'b10:   state_nxt = OWN1;
          2'b11:   state_nxt = last ? OWN0 : OWN1;
          default: state_nxt = IDLE;
        endcase
      end
      OWN0: begin
        if (!req[0]) begin
          state_nxt = req[1] ? OWN1 : IDLE;
        end else begin
          xfer = 1'b1;
          if (req[1] && cnt == CNT_MAX) state_nxt = OWN1;
        end
      end
      OWN1: begin
        if (!req[1]) begin
          state_nxt = req[0] ? OWN0 : IDLE;
        end else begin
          xfer = 1'b1;
          if (req[0] && cnt == CNT_MAX) state_nxt = OWN0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new tenure starts whenever the owner changes, including OWN0<->OWN1.
  assign enter = (state_nxt != IDLE) && (state_nxt != state);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (enter) begin
        cnt  <= '0;
        last <= (state_nxt == OWN1);
      end else if (xfer && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: the data register is reset too, because dout is observable and must
  // read zero after reset rather than whatever was captured before.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= xfer;
      if (xfer) dout <= (state == OWN1) ? din1 : din0;
    end
  end

  assign gnt = {state == OWN1, state == OWN0};
  assign sel = (state == OWN1);

endmodule

// File: tb/tb_arb2x1.sv
// Table-driven bench for arb2x1: directed vectors with expected outputs,
// plus hand-written sequences for reset timing and async mid-tenure reset.
module tb_arb2x1;

  localparam int WIDTH = 8;
  localparam int OW    = 2 + 1 + WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [WIDTH-1:0] din0 = '0;
  logic [WIDTH-1:0] din1 = '0;
  logic [1:0]       gnt;
  logic             sel;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [1:0]       gnt;
    logic             sel;
    logic [WIDTH-1:0] dout;
    logic             valid;
  } vec_t;

  vec_t vecs[$];

  arb2x1 #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got gnt/sel/dout/valid=%h, expected %h", name, got, exp);
  endtask

  task automatic add_v(input logic r, input logic [1:0] q, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [1:0] g, input logic s,
                       input logic [WIDTH-1:0] d, input logic v);
    vec_t t;
    t.rst = r; t.req = q; t.d0 = a; t.d1 = b;
    t.gnt = g; t.sel = s; t.dout = d; t.valid = v;
    vecs.push_back(t);
  endtask

  function automatic logic [OW-1:0] outs();
    return {gnt, sel, dout, dout_valid};
  endfunction

  initial begin
    // Idle after reset release: nothing changes.
    for (int k = 0; k < 5; k++) add_v(0, 2'b00, 8'h11, 8'h22, 2'b00, 0, 8'h00, 0);
    // Single requester, data changing mid-tenure, then drop.
    add_v(0, 2'b01, 8'hA5, 8'h00, 2'b01, 0, 8'h00, 0);
    add_v(0, 2'b01, 8'hA5, 8'h00, 2'b01, 0, 8'hA5, 1);
    add_v(0, 2'b01, 8'h3C, 8'h00, 2'b01, 0, 8'h3C, 1);
    add_v(0, 2'b00, 8'h77, 8'h00, 2'b00, 0, 8'h3C, 0);
    add_v(0, 2'b00, 8'h78, 8'h00, 2'b00, 0, 8'h3C, 0);
    // Continuous contention from reset: 4 words per tenure, alternating.
    add_v(1, 2'b11, 8'hFF, 8'hFF, 2'b00, 0, 8'h00, 0);
    for (int k = 1; k <= 16; k++) begin
      logic       nxt_own;
      logic       cur_own;
      logic [7:0] d;
      nxt_own = ((k - 1) / 4) % 2;
      cur_own = ((k - 2) / 4) % 2;
      d = (k == 1) ? 8'h00 : (cur_own ? 8'(8'h80 + k) : 8'(k));
      add_v(0, 2'b11, 8'(k), 8'(8'h80 + k), nxt_own ? 2'b10 : 2'b01, nxt_own, d, k >= 2);
    end
    // Late arrival after the counter saturated.
    add_v(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 0);
    for (int k = 1; k <= 10; k++)
      add_v(0, 2'b01, 8'(8'h10 + k), 8'(8'h40 + k), 2'b01, 0,
            (k == 1) ? 8'h00 : 8'(8'h10 + k), k >= 2);
    add_v(0, 2'b11, 8'h1B, 8'h4B, 2'b10, 1, 8'h1B, 1);
    add_v(0, 2'b11, 8'h1C, 8'h4C, 2'b10, 1, 8'h4C, 1);
    // Owner drops while peer waits: direct switch, no transfer at the drop edge.
    add_v(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 0);
    add_v(0, 2'b11, 8'h21, 8'h61, 2'b01, 0, 8'h00, 0);
    add_v(0, 2'b11, 8'h22, 8'h62, 2'b01, 0, 8'h22, 1);
    add_v(0, 2'b10, 8'h23, 8'h63, 2'b10, 1, 8'h22, 0);
    add_v(0, 2'b10, 8'h24, 8'h64, 2'b10, 1, 8'h64, 1);

    // Reset asserted before the first edge clears outputs immediately.
    #1;
    req  = 2'($urandom);
    din0 = 8'($urandom);
    din1 = 8'($urandom);
    rst  = 1'b1;
    #1 check("reset_pre_edge", outs(), '0);
    @(posedge clk);
    #1 check("reset_held_edge", outs(), '0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      req  = vecs[i].req;
      din0 = vecs[i].d0;
      din1 = vecs[i].d1;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), outs(),
               {vecs[i].gnt, vecs[i].sel, vecs[i].dout, vecs[i].valid});
    end

    // Async reset between edges while OWN1 is active.
    #2 rst = 1'b1;
    #1 check("async_rst_mid_tenure", outs(), '0);
    req  = 2'b11;
    din0 = 8'h31;
    din1 = 8'h71;
    @(posedge clk);
    #1 check("rst_held_with_req", outs(), '0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("post_rst_tie_own0", outs(), {2'b01, 1'b0, 8'h00, 1'b0});
    din0 = 8'h32;
    @(posedge clk);
    #1 check("post_rst_first_xfer", outs(), {2'b01, 1'b0, 8'h32, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arb2x1.md
# arb2x1

Two-requester round-robin arbiter built around the 2:1 data mux. It grants one of two producers access to a shared single-output data path, drives the mux select, and registers the selected data with a valid strobe. Contention is handled by a bounded hold counter, so neither requester can starve the other. It sits between two upstream producers and one downstream consumer that accepts one word per cycle.

## Interface
Parameters:
- WIDTH, 8, data width of each requester and of the output.
- MAX_HOLD, 4, maximum consecutive transfers one requester keeps the grant while the other is requesting (≥1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  2  request; req[0] for requester 0, req[1] for requester 1.
- din0  input  WIDTH  data from requester 0.
- din1  input  WIDTH  data from requester 1.
- gnt  output  2  one-hot grant, {own1, own0}; 2'b00 when idle.
- sel  output  1  mux select: 1 when requester 1 owns the path, else 0.
- dout  output  WIDTH  registered selected data.
- dout_valid  output  1  dout was loaded at the last edge.

## Operation
- FSM states: IDLE, OWN0, OWN1. Internal registers:
  - cnt: transfers in the current tenure, range 0..MAX_HOLD-1, saturating.
  - last: last owner.
- Decode:
  - gnt = {state==OWN1, state==OWN0}.
  - sel = (state==OWN1).
- Transfer: at an edge with state==OWNx and req[x]==1:
  - dout <= dinx, dout_valid <= 1.
  - cnt increments, saturating at MAX_HOLD-1.
  - Otherwise dout_valid <= 0 and dout holds.
- IDLE transitions, evaluated at each edge:
  - No req: stay in IDLE.
  - Only req[0]: go to OWN0.
  - Only req[1]: go to OWN1.
  - Both: go to OWN(~last).
- OWNx transitions, where y is the other requester:
  - req[x]==0 and req[y]==1: go to OWNy. No transfer.
  - req[x]==0 and req[y]==0: go to IDLE.
  - req[x]==1, req[y]==1, cnt==MAX_HOLD-1: transfer, then go to OWNy.
  - Otherwise: transfer and stay.
- Every entry into OWNx clears cnt to 0 and sets last <= x.
- Uncontended owner keeps the grant indefinitely; cnt saturates.
  - When the other requester then arrives, the owner gets exactly one more transfer at that edge, then the grant switches.
- Ownership may pass directly OWN0↔OWN1 with no IDLE cycle. Under continuous contention, throughput is one word per cycle.
- Arbiter is non-preemptive inside a tenure except via the MAX_HOLD rule.

## Timing
- Inputs are sampled on the rising edge of clk. All outputs are registered; none is combinational from inputs.
- Latency:
  - req rise to gnt: 1 cycle.
  - gnt to first dout_valid: 1 cycle.
  - req to dout: 2 cycles from IDLE.
- Reset values: state IDLE, gnt 2'b00, sel 0, dout 0, dout_valid 0, cnt 0, last 1 (so req[0] wins the first tie).
- rst assertion clears all of the above immediately, independent of clk, including mid-tenure. The first edge after release evaluates from IDLE.
- Requester x may change dinx every cycle. The value present at the transfer edge is the one captured.
- Simultaneous owner-drop and other-request: immediate switch, no transfer that edge.

## Test plan
- Reset: rst=1 with random req/din → gnt=00, sel=0, dout=0, dout_valid=0 before any edge. Release with req=00 for 5 cycles → outputs unchanged.
- Single requester: req=01, din0=8'hA5 from edge 1.
  - After edge 1: gnt=01, sel=0.
  - After edge 2: dout=A5, dout_valid=1.
  - Drop req at edge 4 → IDLE, dout_valid=0, dout holds the last value.
- Contention, MAX_HOLD=4, req=11 from reset release, din0 increments from 0x00, din1 increments from 0x80:
  - gnt=01 for 4 cycles, then 10 for 4, alternating.
  - dout_valid=1 continuously from edge 2.
  - Exactly 4 words from each source per tenure, in order.
- Late arrival: req=01 for 10 cycles (cnt saturated), then req[1] rises → one more din0 transfer at that edge, then gnt=10 at the next edge.
- Owner drop with waiting peer: in OWN0 with req=11, drop req[0] → gnt=10 after that edge, no IDLE cycle, no transfer at the drop edge.
- Async reset mid-tenure: assert rst between edges during OWN1 → all outputs zero before the next edge. Release with req=11 → OWN0 granted first (last=1).
